masked_xor_fold: RTL

- Parametrised successor of the 3-share full-XOR unmasking block.
- Takes N_SHARES Boolean shares of a K_WIDTH word and securely folds them into one unmasked word.
- Folding runs through a pipeline of ceil(log2(N_SHARES)) refresh/fold layers, using N_SHARES-1 fresh random words.
- Sits at the tail of the masked B2A / share-compression datapath, downstream of the masked adders; stalls on a shared randomness-valid enable.

---
 rtl/masked_xor_pkg.sv | 43 ++++
 rtl/masked_xor_fold_layer.sv | 53 +++++
 rtl/masked_xor_fold.sv | 131 +++++++++++++
 3 files changed

// File: rtl/masked_xor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : masked_xor_pkg
// Brief    : Layer geometry helpers for the masked XOR share-folding tree.
// Revision : 1.0 - initial release
// ============================================================================
package masked_xor_pkg;

    // m_0 = n, m_{l+1} = ceil(m_l / 2)
    function automatic int shares_at_layer(input int n, input int l);
        int m;
        m = n;
        for (int k = 0; k < l; k++) begin
            m = (m + 1) / 2;
        end
        return m;
    endfunction

    function automatic int rand_at_layer(input int n, input int l);
        return shares_at_layer(n, l) / 2;
    endfunction

    function automatic int rand_offset(input int n, input int l);
        int off;
        off = 0;
        for (int k = 0; k < l; k++) begin
            off += rand_at_layer(n, k);
        end
        return off;
    endfunction

    // Word offset of layer l's input bus inside the flattened share chain
    function automatic int share_offset(input int n, input int l);
        int off;
        off = 0;
        for (int k = 0; k < l; k++) begin
            off += shares_at_layer(n, k);
        end
        return off;
    endfunction

endpackage
`default_nettype wire

// File: rtl/masked_xor_fold_layer.sv
`default_nettype none
// ============================================================================
// Module   : masked_xor_fold_layer
// Brief    : One refresh / register / fold layer of the masked XOR tree.
// Revision : 1.0 - initial release
// ============================================================================
module masked_xor_fold_layer #(
    parameter int K_WIDTH = 32,
    parameter int M_IN    = 3
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              i_en,
    input  logic [K_WIDTH*M_IN-1:0]           i_x,
    input  logic [K_WIDTH*(M_IN/2)-1:0]       i_r,
    output logic [K_WIDTH*((M_IN+1)/2)-1:0]   o_x
);

    localparam int c_n_pair = M_IN / 2;
    localparam int c_m_out  = (M_IN + 1) / 2;

    logic [K_WIDTH*M_IN-1:0] w_refresh;
    logic [K_WIDTH*M_IN-1:0] r_share;

    // Both members of a pair get the same mask so the pair XOR is unchanged
    for (genvar j = 0; j < M_IN; j++) begin : g_refresh
        if (j / 2 < c_n_pair) begin : g_pair
            assign w_refresh[j*K_WIDTH +: K_WIDTH] =
                i_x[j*K_WIDTH +: K_WIDTH] ^ i_r[(j/2)*K_WIDTH +: K_WIDTH];
        end else begin : g_pass
            assign w_refresh[j*K_WIDTH +: K_WIDTH] = i_x[j*K_WIDTH +: K_WIDTH];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_share <= '0;
        end else if (i_en) begin
            r_share <= w_refresh;
        end
    end

    for (genvar j = 0; j < c_m_out; j++) begin : g_fold
        if (2*j + 1 < M_IN) begin : g_pair
            assign o_x[j*K_WIDTH +: K_WIDTH] =
                r_share[(2*j)*K_WIDTH +: K_WIDTH] ^ r_share[(2*j+1)*K_WIDTH +: K_WIDTH];
        end else begin : g_pass
            assign o_x[j*K_WIDTH +: K_WIDTH] = r_share[(2*j)*K_WIDTH +: K_WIDTH];
        end
    end

endmodule
`default_nettype wire

// File: rtl/masked_xor_fold.sv
`default_nettype none
// ============================================================================
// Module   : masked_xor_fold
// Brief    : Folds N Boolean shares into one unmasked word through a
//            pipelined tree of refresh/fold layers with stall support.
// Revision : 1.0 - initial release
// ============================================================================
module masked_xor_fold
    import masked_xor_pkg::*;
#(
    parameter int K_WIDTH  = 32,
    parameter int N_SHARES = 3,
    parameter int OUT_REG  = 0,
    parameter int LAYERS   = $clog2(N_SHARES),
    parameter int RANDNUM  = N_SHARES - 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          i_dvld,
    input  logic                          i_rvld,
    input  logic [K_WIDTH*RANDNUM-1:0]    i_n,
    input  logic [K_WIDTH*N_SHARES-1:0]   i_x,
    output logic                          o_ready,
    output logic [K_WIDTH-1:0]            o_z,
    output logic                          o_dvld,
    output logic                          o_busy
);

    if (N_SHARES < 2) begin : g_bad_n
        $error("masked_xor_fold: N_SHARES must be at least 2");
    end

    localparam int c_chain_w  = K_WIDTH * share_offset(N_SHARES, LAYERS + 1);
    localparam int c_last_off = K_WIDTH * share_offset(N_SHARES, LAYERS);

    logic [LAYERS:0]      w_vld;
    logic [LAYERS:1]      r_vld;
    logic [c_chain_w-1:0] w_chain;
    logic [K_WIDTH-1:0]   w_fold;

    assign o_ready = i_rvld;
    assign w_vld   = {r_vld, i_dvld};

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_vld <= '0;
        end else if (i_rvld) begin
            r_vld <= w_vld[LAYERS-1:0];
        end
    end

    // Every layer's input/output bus lives in one flat chain; layer 0 input is i_x
    assign w_chain[K_WIDTH*N_SHARES-1:0] = i_x;
    assign w_fold = w_chain[c_last_off +: K_WIDTH];

    for (genvar l = 0; l < LAYERS; l++) begin : g_layer
        localparam int c_m_in    = shares_at_layer(N_SHARES, l);
        localparam int c_m_out   = shares_at_layer(N_SHARES, l + 1);
        localparam int c_r_cnt   = rand_at_layer(N_SHARES, l);
        localparam int c_r_off   = rand_offset(N_SHARES, l);
        localparam int c_in_off  = K_WIDTH * share_offset(N_SHARES, l);
        localparam int c_out_off = K_WIDTH * share_offset(N_SHARES, l + 1);

        logic [K_WIDTH*c_r_cnt-1:0] w_rand;

        if (l == 0) begin : g_rand_direct
            assign w_rand = i_n[K_WIDTH*c_r_off +: K_WIDTH*c_r_cnt];
        end else begin : g_rand_delayed
            // Words ride alongside their token: each stage moves only with it
            logic [K_WIDTH*c_r_cnt-1:0] r_dly [l];

            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    for (int s = 0; s < l; s++) begin
                        r_dly[s] <= '0;
                    end
                end else if (i_rvld) begin
                    if (w_vld[0]) begin
                        r_dly[0] <= i_n[K_WIDTH*c_r_off +: K_WIDTH*c_r_cnt];
                    end
                    for (int s = 1; s < l; s++) begin
                        if (w_vld[s]) begin
                            r_dly[s] <= r_dly[s-1];
                        end
                    end
                end
            end

            assign w_rand = r_dly[l-1];
        end

        masked_xor_fold_layer #(
            .K_WIDTH (K_WIDTH),
            .M_IN    (c_m_in)
        ) u_layer (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .i_en   (i_rvld & w_vld[l]),
            .i_x    (w_chain[c_in_off +: K_WIDTH*c_m_in]),
            .i_r    (w_rand),
            .o_x    (w_chain[c_out_off +: K_WIDTH*c_m_out])
        );
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [K_WIDTH-1:0] r_z;
        logic               r_out_vld;

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                r_z       <= '0;
                r_out_vld <= 1'b0;
            end else if (i_rvld) begin
                r_out_vld <= w_vld[LAYERS];
                if (w_vld[LAYERS]) begin
                    r_z <= w_fold;
                end
            end
        end

        assign o_z    = r_z;
        assign o_dvld = r_out_vld;
        assign o_busy = (|r_vld) | r_out_vld;
    end else begin : g_out_comb
        assign o_z    = w_fold;
        assign o_dvld = w_vld[LAYERS];
        assign o_busy = |r_vld;
    end

endmodule
`default_nettype wire
